tx_sequencer: RTL and testbench
===============================

Name: tx_sequencer

Overview:
- Controller for the 8-bit bidirectional transfer register that sits between mbus and abus.
- Arbitrates between two requesters (0: microcode, 1: DMA) using round-robin.
- Sequences a complete move for the granted requester: source-bus load, wait for the destination bus to be free, destination-bus drive, then acknowledge.
- Generates the register's four active-low strobes (aloadn, mloadn, aoutn, moutn). It never asserts conflicting combinations of them.

Parameters:
- DRIVE_CYCLES, 1, number of cycles the destination output enable is held low; legal range 1..4.
- TIMEOUT_W, 4, width of the destination-wait timeout counter; used only when TX_SEQ_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req0  input  1  transfer request from requester 0; level, held until ack0.
- dir0  input  1  direction for requester 0: 0 = mbus->abus, 1 = abus->mbus.
- req1  input  1  transfer request from requester 1.
- dir1  input  1  direction for requester 1.
- mbus_free  input  1  high = no other device is driving mbus.
- abus_free  input  1  high = no other device is driving abus.
- ack0  output  1  one-cycle completion pulse to requester 0.
- ack1  output  1  one-cycle completion pulse to requester 1.
- err  output  1  one-cycle pulse coincident with ack; transfer timed out.
- grant  output  1  index of the requester currently being served; valid while busy.
- busy  output  1  high in every state except IDLE.
- aloadn  output  1  register load from abus, active-low.
- mloadn  output  1  register load from mbus, active-low.
- aoutn  output  1  register drives abus, active-low.
- moutn  output  1  register drives mbus, active-low.
- dst_stb  output  1  high in the last DRIVE cycle; destination device latches at the end of it.

Behaviour:
- All outputs are registered. During reset: strobes = 1, ack0/ack1/err/dst_stb/busy = 0, grant = 0, round-robin pointer favours requester 0. Reset acts asynchronously; an in-flight transfer is abandoned and no ack is issued.
- States: IDLE, LOAD, WAIT_DST, DRIVE, ACK.
- IDLE:
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that was not granted last.
  - Latch the granted requester's dir into an internal register, then go to LOAD.
- LOAD (exactly 1 cycle):
  - Assert the source-bus load strobe: mloadn = 0 if dir = 0, aloadn = 0 if dir = 1.
  - The register captures at the closing edge.
  - Next state is DRIVE if the destination free input is high, otherwise WAIT_DST.
- WAIT_DST:
  - All strobes inactive.
  - Move to DRIVE on the first edge where the destination free input is high.
- DRIVE (DRIVE_CYCLES cycles, counted by an internal counter):
  - Assert the destination output strobe: aoutn = 0 if dir = 0, moutn = 0 if dir = 1.
  - dst_stb is high only in the final DRIVE cycle.
  - A destination free input dropping during DRIVE is ignored.
- ACK (1 cycle):
  - ack[grant] = 1; update the round-robin pointer to grant; return to IDLE.
- Minimum latency: request sampled at edge N -> ack high in cycle N+2+DRIVE_CYCLES.
- dir and grant are frozen from IDLE exit until ACK completes; changes on dir inputs mid-transfer have no effect.
- A req that drops before ACK does not abort the transfer; the ack still pulses.
- A req still high in the IDLE cycle after ACK is treated as a new request, subject to arbitration.
- Invariants, checked by assertion:
  - At most one of aloadn, mloadn is low.
  - At most one of aoutn, moutn is low.
  - No load strobe and out strobe are low in the same cycle.
  - At most one ack is high.

Optional Feature:
- Macro: TX_SEQ_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to WAIT_DST and increments each WAIT_DST cycle.
  - When it reaches all-ones with the destination still not free, skip DRIVE and go to ACK with err = 1.
  - No output strobe is asserted on a timed-out transfer.
- Not defined: WAIT_DST waits indefinitely; err is tied 0.

Test Plan:
- Single mbus->abus move: release reset; req0 = 1, dir0 = 0, abus_free = 1, DRIVE_CYCLES = 1. Required: mloadn low 1 cycle, next cycle aoutn low with dst_stb = 1, next cycle ack0 = 1; 0x5A on mbus appears on abus.
- Simultaneous requests: req0 = req1 = 1 from reset. Required: grant = 0 first, then grant = 1, then 0 again; acks alternate; busy stays low exactly one IDLE cycle between transfers.
- Destination stall: req1 = 1, dir1 = 1, mbus_free = 0 for 5 cycles. Required: 5 WAIT_DST cycles with all strobes high; moutn low on the cycle after mbus_free rises; ack1 two cycles later.
- Reset mid-transfer: assert reset during DRIVE. Required: aoutn/moutn return to 1 immediately (no clock); no ack; after release, IDLE with pointer favouring requester 0.
- Timeout (macro defined, TIMEOUT_W = 4): abus_free held 0. Required: after 15 WAIT_DST cycles, ack0 = 1 and err = 1 together; aoutn never low. Without the macro, same stimulus keeps busy = 1 indefinitely with err = 0.
- DRIVE_CYCLES = 3: required aoutn low for 3 consecutive cycles, with dst_stb high only in the third.

Source files
------------

// File: rtl/tx_sequencer.sv
// tx_sequencer: round-robin controller that sequences moves through the 8-bit mbus/abus transfer register
// Optional feature macro: TX_SEQ_TIMEOUT_EN (bounded destination wait; a timed-out move acks with err).
// Ports:
//   clk, reset             system clock; asynchronous active-low reset
//   req0/dir0, req1/dir1   level requests (held until ack) and directions (0 = mbus->abus, 1 = abus->mbus)
//   mbus_free, abus_free   high when no other device drives that bus
//   ack0, ack1, err        one-cycle completion pulses; err marks a timed-out move
//   grant, busy            requester being served, valid while busy
//   aloadn, mloadn         active-low register load from abus / mbus
//   aoutn, moutn           active-low register drive onto abus / mbus
//   dst_stb                high in the last drive cycle
module tx_sequencer #(
    parameter int DRIVE_CYCLES = 1,
    parameter int TIMEOUT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic dir0,
    input  logic req1,
    input  logic dir1,
    input  logic mbus_free,
    input  logic abus_free,
    output logic ack0,
    output logic ack1,
    output logic err,
    output logic grant,
    output logic busy,
    output logic aloadn,
    output logic mloadn,
    output logic aoutn,
    output logic moutn,
    output logic dst_stb
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_DST, DRIVE, ACK} state_t;
    state_t state;
    logic dir, last, pick, pick_dir, dst_free, drive_last;
    logic [1:0] cnt;
`ifdef TX_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tcnt;
`endif
    if (DRIVE_CYCLES < 1 || DRIVE_CYCLES > 4 || TIMEOUT_W < 1) begin : g_bad_param
        $error("tx_sequencer: DRIVE_CYCLES must be 1..4 and TIMEOUT_W at least 1");
    end
    // last holds the previously granted requester; on a tie the other one wins
    assign pick       = (req0 && req1) ? ~last : req1;
    assign pick_dir   = pick ? dir1 : dir0;
    assign dst_free   = dir ? mbus_free : abus_free;
    assign drive_last = cnt == 2'(DRIVE_CYCLES - 1);
    // outputs are registered, so every branch sets the values for the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            dir     <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
            grant   <= 1'b0;
            busy    <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err     <= 1'b0;
            dst_stb <= 1'b0;
            aloadn  <= 1'b1;
            mloadn  <= 1'b1;
            aoutn   <= 1'b1;
            moutn   <= 1'b1;
`ifdef TX_SEQ_TIMEOUT_EN
            tcnt    <= '0;
`endif
        end else begin
            {ack0, ack1, err, dst_stb} <= '0;
            {aloadn, mloadn, aoutn, moutn} <= '1;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state  <= LOAD;
                        busy   <= 1'b1;
                        grant  <= pick;
                        dir    <= pick_dir;
                        mloadn <= pick_dir;
                        aloadn <= ~pick_dir;
                    end
                end
                LOAD, WAIT_DST: begin
                    if (dst_free) begin
                        state   <= DRIVE;
                        cnt     <= '0;
                        aoutn   <= dir;
                        moutn   <= ~dir;
                        dst_stb <= DRIVE_CYCLES == 1;
`ifdef TX_SEQ_TIMEOUT_EN
                    end else if (state == WAIT_DST && &(tcnt + 1'b1)) begin
                        state <= ACK;
                        err   <= 1'b1;
                        ack0  <= ~grant;
                        ack1  <= grant;
                    end else begin
                        state <= WAIT_DST;
                        tcnt  <= (state == LOAD) ? '0 : tcnt + 1'b1;
                    end
`else
                    end else begin
                        state <= WAIT_DST;
                    end
`endif
                end
                DRIVE: begin
                    if (drive_last) begin
                        state <= ACK;
                        ack0  <= ~grant;
                        ack1  <= grant;
                    end else begin
                        cnt     <= cnt + 2'd1;
                        aoutn   <= dir;
                        moutn   <= ~dir;
                        dst_stb <= cnt + 2'd2 == 2'(DRIVE_CYCLES);
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    last  <= grant;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
    assert property (@(posedge clk) disable iff (!reset) aloadn || mloadn);
    assert property (@(posedge clk) disable iff (!reset) aoutn || moutn);
    assert property (@(posedge clk) disable iff (!reset) (aloadn && mloadn) || (aoutn && moutn));
    assert property (@(posedge clk) disable iff (!reset) !(ack0 && ack1));
endmodule

// File: tb/tb_tx_sequencer.sv
// tb_tx_sequencer: scoreboard bench for tx_sequencer (DRIVE_CYCLES = 1 and 3 instances)
module tb_tx_sequencer;
    typedef struct {
        int idx;
        int e;
        int ml;
        int al;
        int ao;
        int mo;
        int spos;
        int lat;
        int data;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0 = 1'b0, dir0 = 1'b0, req1 = 1'b0, dir1 = 1'b0, r3 = 1'b0;
    logic mbus_free = 1'b1, abus_free = 1'b1;
    logic ack0, ack1, err, grant, busy, aloadn, mloadn, aoutn, moutn, dst_stb;
    logic b_ack0, b_ack1, b_err, b_grant, b_busy, b_aloadn, b_mloadn, b_aoutn, b_moutn, b_stb;
    logic [7:0] mbus_val = 8'h5A, abus_val = 8'hC3, treg_a = 8'h00, treg_b = 8'h00;
    exp_t qa[$], qb[$];
    int nvec = 0, nbad = 0;
    int lat[2], cml[2], cal[2], cao[2], cmo[2], drv[2], spos[2], cap[2];
    always #5 clk = ~clk;
    tx_sequencer #(.DRIVE_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .req0(req0), .dir0(dir0), .req1(req1), .dir1(dir1),
        .mbus_free(mbus_free), .abus_free(abus_free), .ack0(ack0), .ack1(ack1), .err(err),
        .grant(grant), .busy(busy), .aloadn(aloadn), .mloadn(mloadn), .aoutn(aoutn),
        .moutn(moutn), .dst_stb(dst_stb)
    );
    tx_sequencer #(.DRIVE_CYCLES(3)) u3 (
        .clk(clk), .reset(reset), .req0(r3), .dir0(1'b0), .req1(1'b0), .dir1(1'b0),
        .mbus_free(mbus_free), .abus_free(abus_free), .ack0(b_ack0), .ack1(b_ack1), .err(b_err),
        .grant(b_grant), .busy(b_busy), .aloadn(b_aloadn), .mloadn(b_mloadn), .aoutn(b_aoutn),
        .moutn(b_moutn), .dst_stb(b_stb)
    );
    // model of the transfer register: captures the source bus while its load strobe is low
    always @(posedge clk) begin
        if (!mloadn) treg_a <= mbus_val;
        if (!aloadn) treg_a <= abus_val;
        if (!b_mloadn) treg_b <= mbus_val;
        if (!b_aloadn) treg_b <= abus_val;
    end
    task automatic chk(input string n, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", n, act, exp);
        end
    endtask
    task automatic expect_tx(input int k, input int idx, input int e, input int ml, input int al,
                             input int ao, input int mo, input int sp, input int lt, input int d);
        exp_t x;
        x = '{idx, e, ml, al, ao, mo, sp, lt, d};
        if (k == 0) qa.push_back(x);
        else qb.push_back(x);
    endtask
    task automatic clr(input int k);
        lat[k] = 0; cml[k] = 0; cal[k] = 0; cao[k] = 0;
        cmo[k] = 0; drv[k] = 0; spos[k] = 0; cap[k] = 0;
    endtask
    task automatic observe(input int k, input logic a0, a1, e, g, b, al, ml, ao, mo, st,
                           input logic [7:0] rv);
        exp_t x;
        if (b) lat[k]++;
        if (!ml) cml[k]++;
        if (!al) cal[k]++;
        if (!ao) cao[k]++;
        if (!mo) cmo[k]++;
        if (!ao || !mo) drv[k]++;
        if (st) begin
            spos[k] = drv[k];
            cap[k] = int'(rv);
        end
        if (a0 || a1) begin
            if ((k == 0 ? qa.size() : qb.size()) == 0) begin
                nvec++;
                nbad++;
                $display("FAIL dut%0d unexpected_ack: got ack0=%0d ack1=%0d, expected none", k, a0, a1);
            end else begin
                if (k == 0) x = qa.pop_front();
                else x = qb.pop_front();
                chk($sformatf("dut%0d ack_index", k), int'(a1), x.idx);
                chk($sformatf("dut%0d grant", k), int'(g), x.idx);
                chk($sformatf("dut%0d err", k), int'(e), x.e);
                chk($sformatf("dut%0d mloadn_cycles", k), cml[k], x.ml);
                chk($sformatf("dut%0d aloadn_cycles", k), cal[k], x.al);
                chk($sformatf("dut%0d aoutn_cycles", k), cao[k], x.ao);
                chk($sformatf("dut%0d moutn_cycles", k), cmo[k], x.mo);
                chk($sformatf("dut%0d dst_stb_position", k), spos[k], x.spos);
                chk($sformatf("dut%0d busy_cycles", k), lat[k], x.lat);
                chk($sformatf("dut%0d dest_data", k), cap[k], x.data);
            end
            clr(k);
        end
    endtask
    always @(negedge clk) begin
        if (!reset) begin
            clr(0);
            clr(1);
        end else begin
            observe(0, ack0, ack1, err, grant, busy, aloadn, mloadn, aoutn, moutn, dst_stb, treg_a);
            observe(1, b_ack0, b_ack1, b_err, b_grant, b_busy, b_aloadn, b_mloadn, b_aoutn, b_moutn,
                    b_stb, treg_b);
        end
    end
    task automatic wait_ack(input int k, input string n);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (k == 0 ? (ack0 || ack1) : (b_ack0 || b_ack1)) break;
        end
        if (i == 100) begin
            nvec++;
            nbad++;
            $display("FAIL %s: got no ack within 100 cycles, expected an ack", n);
        end
    endtask
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask
    initial begin
        #12;
        chk("reset_strobes", {aloadn, mloadn, aoutn, moutn}, 15);
        chk("reset_pulses", {ack0, ack1, err, dst_stb}, 0);
        chk("reset_busy_grant", {busy, grant}, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        // single mbus->abus move
        expect_tx(0, 0, 0, 1, 0, 1, 0, 1, 3, 'h5A);
        req0 = 1'b1;
        dir0 = 1'b0;
        wait_ack(0, "single_move");
        req0 = 1'b0;
        // abus->mbus move stalled 5 cycles by mbus_free
        expect_tx(0, 1, 0, 0, 1, 0, 1, 1, 8, 'hC3);
        mbus_free = 1'b0;
        dir1 = 1'b1;
        @(posedge clk);
        #1 req1 = 1'b1;
        repeat (6) @(posedge clk);
        #1 mbus_free = 1'b1;
        wait_ack(0, "stall_move");
        req1 = 1'b0;
        // reset while the register drives abus
        req0 = 1'b1;
        dir0 = 1'b0;
        for (int i = 0; i < 20 && aoutn; i++) @(negedge clk);
        chk("reset_mid_reached_drive", int'(aoutn), 0);
        #1 reset = 1'b0;
        #1;
        chk("reset_mid_out_strobes", {aoutn, moutn}, 3);
        chk("reset_mid_busy_acks", {busy, ack0, ack1}, 0);
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        // both requesting from reset: 0, 1, 0 with one idle cycle in between
        expect_tx(0, 0, 0, 1, 0, 1, 0, 1, 3, 'h5A);
        expect_tx(0, 1, 0, 0, 1, 0, 1, 1, 3, 'hC3);
        expect_tx(0, 0, 0, 1, 0, 1, 0, 1, 3, 'h5A);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_ack(0, "both_first");
        @(negedge clk);
        chk("both_idle_gap", int'(busy), 0);
        @(negedge clk);
        chk("both_second_busy", int'(busy), 1);
        chk("both_second_grant", int'(grant), 1);
        wait_ack(0, "both_second");
        req1 = 1'b0;
        wait_ack(0, "both_third");
        req0 = 1'b0;
        // destination never frees
        abus_free = 1'b0;
        req0 = 1'b1;
        dir0 = 1'b0;
`ifdef TX_SEQ_TIMEOUT_EN
        expect_tx(0, 0, 1, 1, 0, 0, 0, 0, 17, 0);
        wait_ack(0, "timeout_move");
        req0 = 1'b0;
`else
        repeat (40) @(negedge clk);
        chk("no_timeout_busy", int'(busy), 1);
        chk("no_timeout_err", int'(err), 0);
        chk("no_timeout_aoutn", int'(aoutn), 1);
        req0 = 1'b0;
        do_reset();
`endif
        abus_free = 1'b1;
        // DRIVE_CYCLES = 3 instance
        expect_tx(1, 0, 0, 1, 0, 3, 0, 3, 5, 'h5A);
        @(posedge clk);
        #1 r3 = 1'b1;
        wait_ack(1, "drive3_move");
        r3 = 1'b0;
        repeat (3) @(negedge clk);
        chk("queues_drained", qa.size() + qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
